// File: rtl/cpu_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: sequencer states and memory access modes.
package cpu_control_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_mode_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_REGREAD   = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALTED    = 3'd6
    } ctrl_state_e;

    // Encoding 3 is undefined and behaves like MEM_NOP.
    function automatic logic is_mem_access(input logic [1:0] mode);
        return (mode == MEM_READ) || (mode == MEM_WRITE);
    endfunction

endpackage

// File: rtl/cpu_control_unit_mem_watchdog.sv
// Memory wait watchdog: counts stalled request cycles, flags expiry combinationally, keeps a sticky fault.
// MEM_TIMEOUT of 0 disables expiry entirely.
module cpu_control_unit_mem_watchdog #(
    parameter int MEM_TIMEOUT   = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic I_clear,
    input  logic I_waiting,
    output logic O_expire,
    output logic O_fault
);
    localparam bit                     WD_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT_M1 = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

    logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
    logic                     fault_q, fault_d;

    always_comb begin
        count_d  = count_q;
        O_expire = WD_EN && I_waiting && (count_q == LIMIT_M1);
        if (I_clear) begin
            count_d = '0;
        end else if (I_waiting) begin
            count_d = count_q + TIMEOUT_WIDTH'(1);
        end
        fault_d = fault_q | O_expire;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign O_fault = fault_q;

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer FETCH..WRITEBACK with memory watchdog; outputs decode the state register.
// Optional CTRL_PERF_COUNT_EN adds retired-instruction and active-cycle counters.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_mem_ready,
    input  logic        I_halt,
    input  logic [1:0]  I_alu_memory_mode,
    input  logic        I_alu_write_rD,
    input  logic        I_alu_write_pc,
    output logic        O_decode_en,
    output logic        O_regread_en,
    output logic        O_alu_en,
    output logic        O_mem_request,
    output logic [1:0]  O_mem_mode,
    output logic        O_mem_is_fetch,
    output logic        O_regfile_write_en,
    output logic        O_pc_write_en,
    output logic        O_pc_increment,
    output logic        O_halted,
`ifdef CTRL_PERF_COUNT_EN
    output logic [15:0] O_retired,
    output logic [31:0] O_cycles,
`endif
    output logic        O_fault
);
    ctrl_state_e state_q, state_d;
    logic        wd_clear, wd_waiting, wd_expire, wd_fault;

    assign wd_waiting = O_mem_request & ~I_mem_ready;
    assign wd_clear   = (state_q != ST_FETCH) && (state_q != ST_MEMORY);

    cpu_control_unit_mem_watchdog #(
        .MEM_TIMEOUT   (MEM_TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_mem_watchdog (
        .I_clk     (I_clk),
        .I_reset   (I_reset),
        .I_clear   (wd_clear),
        .I_waiting (wd_waiting),
        .O_expire  (wd_expire),
        .O_fault   (wd_fault)
    );

    always_comb begin
        state_d            = state_q;
        O_decode_en        = 1'b0;
        O_regread_en       = 1'b0;
        O_alu_en           = 1'b0;
        O_mem_request      = 1'b0;
        O_mem_mode         = MEM_NOP;
        O_mem_is_fetch     = 1'b0;
        O_regfile_write_en = 1'b0;
        O_pc_write_en      = 1'b0;
        O_pc_increment     = 1'b0;
        O_halted           = 1'b0;
        // Ready takes priority over expiry when both land on the same cycle.
        if (!I_reset) begin
            case (state_q)
                ST_FETCH: begin
                    O_mem_request  = 1'b1;
                    O_mem_mode     = MEM_READ;
                    O_mem_is_fetch = 1'b1;
                    if (I_mem_ready)    state_d = ST_DECODE;
                    else if (wd_expire) state_d = ST_HALTED;
                end
                ST_DECODE: begin
                    O_decode_en = 1'b1;
                    state_d     = ST_REGREAD;
                end
                ST_REGREAD: begin
                    O_regread_en = 1'b1;
                    state_d      = I_halt ? ST_HALTED : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    O_alu_en = 1'b1;
                    state_d  = ST_MEMORY;
                end
                ST_MEMORY: begin
                    if (!is_mem_access(I_alu_memory_mode)) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        O_mem_request = 1'b1;
                        O_mem_mode    = I_alu_memory_mode;
                        if (I_mem_ready)    state_d = ST_WRITEBACK;
                        else if (wd_expire) state_d = ST_HALTED;
                    end
                end
                ST_WRITEBACK: begin
                    O_regfile_write_en = I_alu_write_rD;
                    O_pc_write_en      = I_alu_write_pc;
                    O_pc_increment     = ~I_alu_write_pc;
                    state_d            = ST_FETCH;
                end
                default: begin
                    O_halted = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) state_q <= ST_FETCH;
        else         state_q <= state_d;
    end

    assign O_fault = wd_fault & ~I_reset;

`ifdef CTRL_PERF_COUNT_EN
    logic [15:0] retired_q, retired_d;
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        retired_d = retired_q + 16'((state_q == ST_WRITEBACK) ? 1 : 0);
        cycles_d  = cycles_q  + 32'((state_q != ST_HALTED) ? 1 : 0);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign O_retired = I_reset ? 16'd0 : retired_q;
    assign O_cycles  = I_reset ? 32'd0 : cycles_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit (MEM_TIMEOUT=4): per-cycle expected output vectors via a scoreboard queue.
module tb_cpu_control_unit;

    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_mem_ready = 1'b0;
    logic        I_halt = 1'b0;
    logic [1:0]  I_alu_memory_mode = 2'd0;
    logic        I_alu_write_rD = 1'b0;
    logic        I_alu_write_pc = 1'b0;
    logic        O_decode_en, O_regread_en, O_alu_en, O_mem_request;
    logic [1:0]  O_mem_mode;
    logic        O_mem_is_fetch, O_regfile_write_en, O_pc_write_en, O_pc_increment;
    logic        O_halted, O_fault;
`ifdef CTRL_PERF_COUNT_EN
    logic [15:0] O_retired;
    logic [31:0] O_cycles;
`endif

    cpu_control_unit #(.MEM_TIMEOUT(4), .TIMEOUT_WIDTH(8)) dut (
        .I_clk              (I_clk),
        .I_reset            (I_reset),
        .I_mem_ready        (I_mem_ready),
        .I_halt             (I_halt),
        .I_alu_memory_mode  (I_alu_memory_mode),
        .I_alu_write_rD     (I_alu_write_rD),
        .I_alu_write_pc     (I_alu_write_pc),
        .O_decode_en        (O_decode_en),
        .O_regread_en       (O_regread_en),
        .O_alu_en           (O_alu_en),
        .O_mem_request      (O_mem_request),
        .O_mem_mode         (O_mem_mode),
        .O_mem_is_fetch     (O_mem_is_fetch),
        .O_regfile_write_en (O_regfile_write_en),
        .O_pc_write_en      (O_pc_write_en),
        .O_pc_increment     (O_pc_increment),
        .O_halted           (O_halted),
`ifdef CTRL_PERF_COUNT_EN
        .O_retired          (O_retired),
        .O_cycles           (O_cycles),
`endif
        .O_fault            (O_fault)
    );

    always #5 I_clk = ~I_clk;

    // Bit order: decode, regread, alu, mem_request, mem_mode[1:0], is_fetch, rf_we, pc_we, pc_inc, halted, fault
    localparam logic [11:0] E_NONE   = 12'h000;
    localparam logic [11:0] E_FETCH  = 12'h160;
    localparam logic [11:0] E_DEC    = 12'h800;
    localparam logic [11:0] E_RR     = 12'h400;
    localparam logic [11:0] E_EX     = 12'h200;
    localparam logic [11:0] E_MRD    = 12'h140;
    localparam logic [11:0] E_MWR    = 12'h180;
    localparam logic [11:0] E_WB_INC = 12'h004;
    localparam logic [11:0] E_WB_RF  = 12'h014;
    localparam logic [11:0] E_WB_JMP = 12'h018;
    localparam logic [11:0] E_HALT   = 12'h002;
    localparam logic [11:0] E_FAULT  = 12'h003;

    logic [11:0] exp_q[$];
    logic [11:0] obs, want;
    int          n_vec = 0;
    int          n_err = 0;

    assign obs = {O_decode_en, O_regread_en, O_alu_en, O_mem_request, O_mem_mode, O_mem_is_fetch,
                  O_regfile_write_en, O_pc_write_en, O_pc_increment, O_halted, O_fault};

    task automatic step(input logic rst, input logic rdy, input logic hlt, input logic [1:0] md,
                        input logic wrd, input logic wpc, input logic [11:0] exp_v);
        I_reset           = rst;
        I_mem_ready       = rdy;
        I_halt            = hlt;
        I_alu_memory_mode = md;
        I_alu_write_rD    = wrd;
        I_alu_write_pc    = wpc;
        exp_q.push_back(exp_v);
        @(negedge I_clk);
        want = exp_q.pop_front();
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL outputs vec%0d observed=%h expected=%h", n_vec, obs, want);
        end
        @(posedge I_clk);
        #1;
    endtask

    // Memory-phase steps with a request wait mem_wait cycles; non-request memory cycles see rdy=0.
    task automatic run_instr(input int fetch_wait, input logic [1:0] md, input int mem_wait,
                             input logic wrd, input logic wpc,
                             input logic [11:0] mem_exp, input logic [11:0] wb_exp);
        for (int i = 0; i < fetch_wait; i++) step(0, 0, 0, md, wrd, wpc, E_FETCH);
        step(0, 1, 0, md, wrd, wpc, E_FETCH);
        step(0, 1, 0, md, wrd, wpc, E_DEC);
        step(0, 1, 0, md, wrd, wpc, E_RR);
        step(0, 1, 0, md, wrd, wpc, E_EX);
        for (int i = 0; i < mem_wait; i++) step(0, 0, 0, md, wrd, wpc, mem_exp);
        step(0, (mem_exp != E_NONE), 0, md, wrd, wpc, mem_exp);
        step(0, 1, 0, md, wrd, wpc, wb_exp);
    endtask

    initial begin
        @(posedge I_clk);
        #1;
        // Reset masks every output even with active-looking inputs.
        step(1, 1, 1, 2'd2, 1, 1, E_NONE);
        step(1, 1, 1, 2'd2, 1, 1, E_NONE);

        run_instr(0, 2'd0, 0, 1, 0, E_NONE, E_WB_RF);   // zero-wait non-memory instruction
        run_instr(3, 2'd0, 0, 0, 0, E_NONE, E_WB_INC);  // fetch stalled 3 cycles
        run_instr(0, 2'd2, 2, 0, 0, E_MWR, E_WB_INC);   // store, ready after 2
        run_instr(0, 2'd0, 0, 1, 1, E_NONE, E_WB_JMP);  // taken jump
        run_instr(0, 2'd3, 0, 0, 0, E_NONE, E_WB_INC);  // undefined mode acts as NOP
        run_instr(0, 2'd1, 0, 1, 0, E_MRD, E_WB_RF);    // zero-wait load

        // Ready on the limit cycle wins, then HALT instruction.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 0, 0, E_FETCH);
        step(0, 1, 0, 2'd0, 0, 0, E_FETCH);
        step(0, 1, 0, 2'd0, 0, 0, E_DEC);
        step(0, 1, 1, 2'd0, 0, 0, E_RR);
        step(0, 1, 0, 2'd1, 1, 1, E_HALT);
        step(0, 1, 0, 2'd1, 1, 1, E_HALT);
        step(1, 1, 0, 2'd0, 0, 0, E_NONE);

        // Fetch timeout after 4 stalled cycles, sticky until reset.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'd0, 0, 0, E_FETCH);
        step(0, 1, 0, 2'd0, 0, 0, E_FAULT);
        step(0, 1, 0, 2'd0, 0, 0, E_FAULT);
        step(1, 0, 0, 2'd0, 0, 0, E_NONE);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 0, 0, E_FETCH);
        step(0, 1, 0, 2'd0, 0, 0, E_FETCH);
        step(0, 1, 0, 2'd0, 0, 0, E_DEC);

        // Memory-phase timeout.
        step(0, 1, 0, 2'd1, 0, 0, E_RR);
        step(0, 1, 0, 2'd1, 0, 0, E_EX);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'd1, 0, 0, E_MRD);
        step(0, 0, 0, 2'd1, 0, 0, E_FAULT);

`ifdef CTRL_PERF_COUNT_EN
        step(1, 0, 0, 2'd0, 0, 0, E_NONE);
        for (int k = 0; k < 3; k++) run_instr(0, 2'd0, 0, 1, 0, E_NONE, E_WB_RF);
        n_vec++;
        assert (O_retired === 16'd3) else begin
            n_err++;
            $error("FAIL retired observed=%0d expected=3", O_retired);
        end
        n_vec++;
        assert (O_cycles === 32'd18) else begin
            n_err++;
            $error("FAIL cycles observed=%0d expected=18", O_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
